// File: rtl/clock_enable_param_pkg.sv
// Shared defaults and parameter-legality helper for the clock-enable strobe generator.
// Pure constants and a constant function; no logic.
package clock_enable_param_pkg;

   localparam int DEFAULT_WAIT  = 10;
   localparam int DEFAULT_WIDTH = 4;

   // True when a period of wait_cycles clocks can be counted in a width-bit counter.
   function automatic bit wait_fits(input int wait_cycles, input int width);
      return (wait_cycles >= 1) && (width >= 1) && (width < 31) &&
             (wait_cycles <= (1 << width));
   endfunction

endpackage

// File: rtl/clock_enable_param_if.sv
// Strobe output bundle: the enable pulse plus the phase counter for observability.
// Master drives, slave observes; no handshake and no backpressure.
interface clock_enable_param_if
   import clock_enable_param_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             enable;
   logic [WIDTH-1:0] count;

   modport master (output enable, output count);
   modport slave  (input  enable, input  count);

endinterface

// File: rtl/clock_enable_param.sv
// One-cycle enable strobe every WAIT clk cycles, registered output, first pulse WAIT edges after reset.
// Free-running: the strobe has no backpressure; synchronous active-high reset restarts the period.
module clock_enable_param
   import clock_enable_param_pkg::*;
#(
   parameter int WAIT  = DEFAULT_WAIT,
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   clock_enable_param_if.master ce
);

   // Terminal count; the counter wraps here, never relying on natural overflow.
   localparam logic [WIDTH-1:0] TC = WIDTH'(WAIT - 1);

   if (!wait_fits(WAIT, WIDTH)) begin : g_bad_params
      $error("clock_enable_param: WAIT=%0d must be >= 1 and fit in WIDTH=%0d bits", WAIT, WIDTH);
   end

   logic [WIDTH-1:0] count;
   logic             enable;

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         enable <= 1'b0;
      end else if (count == TC) begin
         count  <= '0;
         enable <= 1'b1;
      end else begin
         count  <= count + WIDTH'(1);
         enable <= 1'b0;
      end
   end

   assign ce.enable = enable;
   assign ce.count  = count;

endmodule

// File: tb/tb_clock_enable_param.sv
// Six strobe generators on one clock, checked per cycle against an edge-counting reference model.
`timescale 1ns/1ps
module tb_clock_enable_param;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   clock_enable_param_if #(.WIDTH(4)) if_a ();
   clock_enable_param_if #(.WIDTH(4)) if_b ();
   clock_enable_param_if #(.WIDTH(8)) if_c ();
   clock_enable_param_if #(.WIDTH(8)) if_d ();
   clock_enable_param_if #(.WIDTH(1)) if_e ();
   clock_enable_param_if #(.WIDTH(4)) if_f ();

   clock_enable_param                           u_a (.clk(clk), .reset(reset), .ce(if_a));
   clock_enable_param #(.WAIT(2),  .WIDTH(4))   u_b (.clk(clk), .reset(reset), .ce(if_b));
   clock_enable_param #(.WAIT(3),  .WIDTH(8))   u_c (.clk(clk), .reset(reset), .ce(if_c));
   clock_enable_param #(.WAIT(9),  .WIDTH(8))   u_d (.clk(clk), .reset(reset), .ce(if_d));
   clock_enable_param #(.WAIT(1),  .WIDTH(1))   u_e (.clk(clk), .reset(reset), .ce(if_e));
   clock_enable_param #(.WAIT(16), .WIDTH(4))   u_f (.clk(clk), .reset(reset), .ce(if_f));

   logic [5:0]      en_v;
   logic [5:0][7:0] cnt_v;
   assign en_v = {if_f.enable, if_e.enable, if_d.enable, if_c.enable, if_b.enable, if_a.enable};
   assign cnt_v[0] = 8'(if_a.count);
   assign cnt_v[1] = 8'(if_b.count);
   assign cnt_v[2] = 8'(if_c.count);
   assign cnt_v[3] = 8'(if_d.count);
   assign cnt_v[4] = 8'(if_e.count);
   assign cnt_v[5] = 8'(if_f.count);

   typedef struct packed {
      logic [5:0]      en;
      logic [5:0][7:0] cnt;
      logic            inwin;
   } exp_t;

   exp_t  sb[$];
   int    checks   = 0;
   int    failures = 0;
   int    wv[6]     = '{10, 2, 3, 9, 1, 16};
   int    pc_exp[6] = '{3, 18, 12, 4, 36, 2};
   string nm[6]     = '{"A", "B", "C", "D", "E", "F"};
   int    k[6]      = '{0, 0, 0, 0, 0, 0};
   int    pc[6]     = '{0, 0, 0, 0, 0, 0};
   int    win_left  = 0;
   bit    released  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference: after n consecutive non-reset edges, enable = (n>0 && n%WAIT==0), count = n%WAIT.
   task automatic step(input bit r);
      exp_t e;
      @(negedge clk);
      reset = r;
      e = '0;
      if (!r && !released) begin
         released = 1'b1;
         win_left = 36;
      end
      e.inwin = !r && (win_left > 0);
      if (!r && win_left > 0) win_left--;
      for (int i = 0; i < 6; i++) begin
         if (r) k[i] = 0;
         else   k[i] = k[i] + 1;
         e.en[i]  = !r && ((k[i] % wv[i]) == 0);
         e.cnt[i] = 8'(r ? 0 : (k[i] % wv[i]));
      end
      sb.push_back(e);
   endtask

   task automatic seg(input bit r, input int n);
      for (int j = 0; j < n; j++) step(r);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < 6; i++) begin
               check($sformatf("enable_%s", nm[i]), 32'(en_v[i]), 32'(e.en[i]));
               check($sformatf("count_%s", nm[i]), 32'(cnt_v[i]), 32'(e.cnt[i]));
               check($sformatf("count_range_%s", nm[i]), 32'(int'(cnt_v[i]) < wv[i]), 32'd1);
               if (e.inwin && en_v[i] === 1'b1) pc[i]++;
            end
         end
      end
   end

   initial begin : stimulus
      // Reset held, then a long run covering the 36-cycle pulse-count window.
      seg(1'b1, 3);
      seg(1'b0, 40);
      // One-cycle reset at edge 7: mid-period for C and D.
      seg(1'b1, 2);
      seg(1'b0, 6);
      seg(1'b1, 1);
      seg(1'b0, 30);
      // Reset landing on the edge where B, then A, would pulse.
      seg(1'b0, 1);
      seg(1'b1, 1);
      seg(1'b0, 9);
      seg(1'b1, 1);
      seg(1'b0, 25);
      // Random reset bursts and run lengths.
      for (int s = 0; s < 20; s++) begin
         seg(1'b1, int'($urandom_range(0, 2)));
         seg(1'b0, int'($urandom_range(1, 40)));
      end
      seg(1'b0, 20);

      for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
      check("scoreboard_drain", 32'(sb.size()), 32'd0);
      for (int i = 0; i < 6; i++)
         check($sformatf("pulses_36_%s", nm[i]), 32'(pc[i]), 32'(pc_exp[i]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
